// File: rtl/cpu_types_pkg.sv
// Shared CPU types: fetch sequencer state and the default reset PC.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    HELD   = 2'd1,
    HALTED = 2'd2
  } pc_state_t;

  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/pc_ras.sv
// Return-address stack: circular buffer with a top pointer and a saturating
// count. When full, a push overwrites the oldest entry. Push and pop in the
// same cycle replace the top entry in place.
module pc_ras #(
  parameter int WIDTH     = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [RAS_DEPTH];
  logic [PW-1:0]    ptr;
  logic [CW-1:0]    count;
  logic             do_pop;
  logic             replace;

  assign empty   = (count == '0);
  assign full    = (count == CW'(RAS_DEPTH));
  assign top     = mem[ptr];
  // A pop of an empty stack is ignored; a push then behaves as a plain push.
  assign do_pop  = pop && !empty;
  assign replace = push && do_pop;

  // Top pointer and occupancy count.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      ptr   <= '0;
      count <= '0;
    end else if (replace) begin
      ptr   <= ptr;
    end else if (push) begin
      ptr <= ptr + PW'(1);
      if (!full) count <= count + CW'(1);
    end else if (do_pop) begin
      ptr   <= ptr - PW'(1);
      count <= count - CW'(1);
    end
  end

  // Entry storage; wrapping ptr+1 lands on the oldest entry when full.
  // NOTE: the storage array has no reset; empty/full come from the count,
  // so stale contents are never observed and the array stays plain RAM.
  always_ff @(posedge CLK) begin
    if (replace)   mem[ptr]          <= push_data;
    else if (push) mem[ptr + PW'(1)] <= push_data;
  end

endmodule

// File: rtl/pc_seq.sv
// Fetch-stage program-counter sequencer. Next PC priority: halt, redirect,
// RAS prediction, sequential. Redirects seen while stalled are captured and
// applied on the release cycle.
module pc_seq
  import cpu_types_pkg::*;
#(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_PC    = WIDTH'(PC_RESET_DEFAULT),
  parameter int               INSTR_BYTES = 4,
  parameter int               RAS_DEPTH   = 4
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             pc_en,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  input  logic             call,
  input  logic             ret,
  input  logic             halt,
  output logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] npc,
  output logic             pending,
  output logic             halted,
  output logic             ras_empty,
  output logic             ras_full
);

  // Clears the sub-instruction offset bits of any loaded target.
  localparam logic [WIDTH-1:0] ALIGN_MASK = ~(WIDTH'(INSTR_BYTES) - WIDTH'(1));

  pc_state_t        state, state_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic [WIDTH-1:0] pend_pc, pend_pc_d;
  logic             pend_valid, pend_valid_d;
  logic             ras_push, ras_pop;
  logic [WIDTH-1:0] ras_top;
  logic [WIDTH-1:0] redirect_aligned;

  assign PC               = pc_q;
  assign npc              = pc_q + WIDTH'(INSTR_BYTES);
  assign pending          = pend_valid;
  assign halted           = (state == HALTED);
  assign redirect_aligned = redirect_pc & ALIGN_MASK;

  pc_ras #(
    .WIDTH    (WIDTH),
    .RAS_DEPTH(RAS_DEPTH)
  ) u_ras (
    .CLK      (CLK),
    .nRST     (nRST),
    .push     (ras_push),
    .pop      (ras_pop),
    .push_data(npc),
    .top      (ras_top),
    .empty    (ras_empty),
    .full     (ras_full)
  );

  // Next-state, next-PC priority mux and RAS control.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can leave one unassigned and infer a latch.
    state_d      = state;
    pc_d         = pc_q;
    pend_pc_d    = pend_pc;
    pend_valid_d = pend_valid;
    ras_push     = 1'b0;
    ras_pop      = 1'b0;

    unique case (state)
      RUN: begin
        if (halt) begin
          state_d = HALTED;
        end else if (pc_en) begin
          if (redirect_valid) begin
            pc_d = redirect_aligned;
          end else begin
            if (ret && !ras_empty) begin
              pc_d    = ras_top;
              ras_pop = 1'b1;
            end else begin
              pc_d = npc;
            end
            ras_push = call;
          end
        end else if (redirect_valid) begin
          pend_pc_d    = redirect_aligned;
          pend_valid_d = 1'b1;
          state_d      = HELD;
        end
      end
      HELD: begin
        if (halt) begin
          state_d = HALTED;
        end else if (pc_en) begin
          pc_d         = redirect_valid ? redirect_aligned : pend_pc;
          pend_valid_d = 1'b0;
          state_d      = RUN;
        end else if (redirect_valid) begin
          pend_pc_d = redirect_aligned;
        end
      end
      default: begin
        // HALTED: everything frozen until reset.
        state_d = HALTED;
      end
    endcase
  end

  // Sequencer state registers.
  always_ff @(posedge CLK or negedge nRST) begin
    // NOTE: non-blocking assignments here so every register samples the
    // pre-edge values regardless of statement order.
    if (!nRST) begin
      state      <= RUN;
      pc_q       <= RESET_PC;
      pend_pc    <= '0;
      pend_valid <= 1'b0;
    end else begin
      state      <= state_d;
      pc_q       <= pc_d;
      pend_pc    <= pend_pc_d;
      pend_valid <= pend_valid_d;
    end
  end

endmodule

// File: tb/tb_pc_seq.sv
// Self-checking bench for pc_seq: directed vector table, a frozen-halt and
// async-reset sequence, then randomized traffic against a queue-based model.
module tb_pc_seq;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        pc_en, redirect_valid, call, ret, halt;
  logic [31:0] redirect_pc;
  logic [31:0] PC, npc;
  logic        pending, halted, ras_empty, ras_full;

  int n_checks = 0;
  int n_pass   = 0;

  pc_seq #(
    .WIDTH      (32),
    .RESET_PC   (32'h200),
    .INSTR_BYTES(4),
    .RAS_DEPTH  (4)
  ) dut (
    .CLK           (CLK),
    .nRST          (nRST),
    .pc_en         (pc_en),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .call          (call),
    .ret           (ret),
    .halt          (halt),
    .PC            (PC),
    .npc           (npc),
    .pending       (pending),
    .halted        (halted),
    .ras_empty     (ras_empty),
    .ras_full      (ras_full)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached, got %0t required < 2000000", $time);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        en, rv;
    logic [31:0] rpc;
    logic        cl, rt, hl;
    logic [31:0] pc;
    logic        pend, hlt, emp, full;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic en, input logic rv, input logic [31:0] rpc,
                     input logic cl, input logic rt, input logic hl,
                     input logic [31:0] pc, input logic pend, input logic hlt,
                     input logic emp, input logic full);
    vecs.push_back('{en, rv, rpc, cl, rt, hl, pc, pend, hlt, emp, full});
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
    else n_pass++;
  endtask

  task automatic drive(input logic en, input logic rv, input logic [31:0] rpc,
                       input logic cl, input logic rt, input logic hl);
    pc_en = en; redirect_valid = rv; redirect_pc = rpc; call = cl; ret = rt; halt = hl;
  endtask

  function automatic logic [31:0] flags();
    return {28'h0, pending, halted, ras_empty, ras_full};
  endfunction

  // ---------------- reference model (architectural view) ----------------
  logic [31:0] m_pc;
  logic        m_halted, m_has_pend;
  logic [31:0] m_pend;
  logic [31:0] m_ras[$];   // back = most recent return address

  function automatic logic [31:0] align(input logic [31:0] a);
    return a & ~32'h3;
  endfunction

  task automatic model_reset();
    m_pc = 32'h200; m_halted = 1'b0; m_has_pend = 1'b0; m_pend = '0;
    m_ras.delete();
  endtask

  task automatic model_step();
    logic [31:0] seq;
    seq = m_pc + 32'd4;
    if (m_halted) return;
    if (halt) begin
      m_halted = 1'b1;
    end else if (m_has_pend) begin
      if (pc_en) begin
        m_pc = redirect_valid ? align(redirect_pc) : m_pend;
        m_has_pend = 1'b0;
      end else if (redirect_valid) begin
        m_pend = align(redirect_pc);
      end
    end else if (!pc_en) begin
      if (redirect_valid) begin
        m_pend = align(redirect_pc);
        m_has_pend = 1'b1;
      end
    end else if (redirect_valid) begin
      m_pc = align(redirect_pc);
    end else begin
      if (ret && m_ras.size() > 0) m_pc = m_ras.pop_back();
      else m_pc = seq;
      if (call) begin
        m_ras.push_back(seq);
        if (m_ras.size() > 4) void'(m_ras.pop_front());
      end
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, "_pc"}, PC, m_pc);
    check({tag, "_npc"}, npc, m_pc + 32'd4);
    check({tag, "_flags"}, flags(),
          {28'h0, m_has_pend, m_halted, m_ras.size() == 0, m_ras.size() == 4});
  endtask

  // ---------------------------------------------------------------------
  initial begin
    drive(0, 0, 0, 0, 0, 0);
    nRST = 1'b0;
    repeat (2) @(negedge CLK);
    check("reset_pc", PC, 32'h200);
    check("reset_npc", npc, 32'h204);
    check("reset_flags", flags(), 32'b0010);
    nRST = 1'b1;

    // Directed table: inputs for one cycle, expected state after that edge.
    add(1,0,0,0,0,0, 'h204,       0,0,1,0);
    add(1,0,0,0,0,0, 'h208,       0,0,1,0);
    add(1,0,0,0,0,0, 'h20C,       0,0,1,0);
    add(0,1,'h1000,0,0,0, 'h20C,  1,0,1,0);
    add(0,0,0,0,0,0, 'h20C,       1,0,1,0);
    add(0,0,0,0,0,0, 'h20C,       1,0,1,0);
    add(1,0,0,0,0,0, 'h1000,      0,0,1,0);
    add(0,1,'h1000,0,0,0, 'h1000, 1,0,1,0);
    add(0,1,'h2000,0,0,0, 'h1000, 1,0,1,0);
    add(1,0,0,0,0,0, 'h2000,      0,0,1,0);
    add(1,1,'h40,0,0,0, 'h40,     0,0,1,0);
    add(1,0,0,1,0,0, 'h44,        0,0,0,0);
    add(1,1,'h80,0,0,0, 'h80,     0,0,0,0);
    add(1,0,0,1,0,0, 'h84,        0,0,0,0);
    add(1,0,0,0,1,0, 'h84,        0,0,0,0);
    add(1,0,0,0,1,0, 'h44,        0,0,1,0);
    add(1,0,0,0,1,0, 'h48,        0,0,1,0);
    add(1,1,'h103,0,0,0, 'h100,   0,0,1,0);
    add(1,1,'hFFFFFFFC,0,0,0, 'hFFFFFFFC, 0,0,1,0);
    add(1,0,0,0,0,0, 'h0,         0,0,1,0);
    add(1,1,'h10,0,0,0, 'h10,     0,0,1,0);
    add(1,0,0,1,0,0, 'h14,        0,0,0,0);
    add(1,1,'h20,0,0,0, 'h20,     0,0,0,0);
    add(1,0,0,1,0,0, 'h24,        0,0,0,0);
    add(1,1,'h30,0,0,0, 'h30,     0,0,0,0);
    add(1,0,0,1,0,0, 'h34,        0,0,0,0);
    add(1,1,'h40,0,0,0, 'h40,     0,0,0,0);
    add(1,0,0,1,0,0, 'h44,        0,0,0,1);
    add(1,1,'h50,0,0,0, 'h50,     0,0,0,1);
    add(1,0,0,1,0,0, 'h54,        0,0,0,1);
    add(1,0,0,0,1,0, 'h54,        0,0,0,0);
    add(1,0,0,0,1,0, 'h44,        0,0,0,0);
    add(1,0,0,0,1,0, 'h34,        0,0,0,0);
    add(1,0,0,0,1,0, 'h24,        0,0,1,0);
    add(1,0,0,0,1,0, 'h28,        0,0,1,0);
    add(1,0,0,1,0,0, 'h2C,        0,0,0,0);
    add(1,0,0,1,1,0, 'h2C,        0,0,0,0);
    add(1,0,0,0,1,0, 'h30,        0,0,1,0);
    add(0,1,'h300,1,1,0, 'h30,    1,0,1,0);
    add(1,0,0,1,1,0, 'h300,       0,0,1,0);
    add(1,1,'h400,1,0,0, 'h400,   0,0,1,0);
    add(1,1,'h500,0,0,1, 'h400,   0,1,1,0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge CLK);
      drive(vecs[i].en, vecs[i].rv, vecs[i].rpc, vecs[i].cl, vecs[i].rt, vecs[i].hl);
      @(posedge CLK);
      #1;
      check($sformatf("vec%0d_pc", i), PC, vecs[i].pc);
      check($sformatf("vec%0d_flags", i), flags(),
            {28'h0, vecs[i].pend, vecs[i].hlt, vecs[i].emp, vecs[i].full});
    end

    // Halted: PC frozen for 10 cycles whatever the inputs do.
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      drive(1, 1'($urandom), $urandom, 1'($urandom), 1'($urandom), 1'($urandom));
      @(posedge CLK);
      #1;
      check($sformatf("halt_frozen%0d_pc", i), PC, 32'h400);
      check($sformatf("halt_frozen%0d_flags", i), flags(), 32'b0110);
    end

    // Asynchronous reset mid-halt takes effect without a clock edge.
    @(negedge CLK);
    drive(0, 0, 0, 0, 0, 0);
    #2;
    nRST = 1'b0;
    #1;
    check("halt_reset_pc", PC, 32'h200);
    check("halt_reset_flags", flags(), 32'b0010);
    #1;
    nRST = 1'b1;
    model_reset();

    // Randomized traffic against the model.
    for (int i = 0; i < 800; i++) begin
      @(negedge CLK);
      if (m_halted && $urandom_range(0, 3) == 0) begin
        drive(0, 0, 0, 0, 0, 0);
        #1;
        nRST = 1'b0;
        #1;
        model_reset();
        check_model("rand_reset");
        #1;
        nRST = 1'b1;
      end else begin
        logic [31:0] tgt;
        case ($urandom_range(0, 3))
          0:       tgt = $urandom;
          1:       tgt = 32'hFFFF_FFF0 | ($urandom & 32'hF);
          default: tgt = $urandom & 32'hFFF;
        endcase
        drive($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, tgt,
              $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
              $urandom_range(0, 63) == 0);
        @(posedge CLK);
        model_step();
        #1;
        check_model("rand");
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pc_seq.md
# pc_seq

Parametrised program-counter sequencer for the fetch stage. It holds the fetch PC and selects the next PC by priority: halt, redirect from execute, return-address-stack (RAS) prediction, then sequential increment. A redirect that arrives while fetch is stalled is captured and applied when the stall releases. It replaces the plain enable-gated PC register and feeds the instruction-memory address and the npc path to decode.

## Interface
Parameters:
- WIDTH, 32, PC width in bits
- RESET_PC, 0, PC value on reset
- INSTR_BYTES, 4, sequential increment; power of two, ≥1
- RAS_DEPTH, 4, return-address-stack entries; power of two, ≥2

Ports:
- CLK  in  1  clock
- nRST  in  1  reset, asynchronous, active-low
- pc_en  in  1  advance PC this cycle (0 = stall)
- redirect_valid  in  1  branch/jump resolved; load redirect_pc
- redirect_pc  in  WIDTH  redirect target
- call  in  1  fetched instruction is a call; push return address
- ret  in  1  fetched instruction is a return; pop predicted target
- halt  in  1  stop fetch (sticky)
- PC  out  WIDTH  current fetch PC
- npc  out  WIDTH  PC + INSTR_BYTES, combinational
- pending  out  1  a captured redirect is waiting
- halted  out  1  in HALTED state
- ras_empty  out  1  RAS count == 0
- ras_full  out  1  RAS count == RAS_DEPTH

## Operation
- States: RUN, HELD, HALTED. Reset → RUN.
- Alignment: the low log2(INSTR_BYTES) bits of any loaded target are forced to 0.
- All PC arithmetic is modulo 2^WIDTH. 0xFFFFFFFC + 4 → 0x00000000.
- RUN with pc_en=1, next PC by priority:
  - halt → HALTED, PC unchanged
  - redirect_valid → redirect_pc; call/ret are squashed (no RAS change)
  - ret and !ras_empty → RAS top, pop
  - otherwise → npc; ret with an empty RAS falls through to npc with no pop
- call is honoured whenever pc_en=1 and it is not squashed: push npc.
- call and ret in the same cycle with a non-empty RAS:
  - PC ← old top
  - top is replaced with npc
  - count unchanged
- call when full: overwrite the oldest entry (circular); count stays RAS_DEPTH.
- RUN with pc_en=0:
  - PC holds
  - redirect_valid → capture into the pending register, go to HELD
  - halt → HALTED
- HELD:
  - pc_en=0: a new redirect_valid overwrites the captured target
  - pc_en=1: PC ← redirect_valid ? redirect_pc : captured target; pending clears; → RUN
  - call/ret are ignored for the whole HELD stay and on the release cycle
- HALTED: PC, RAS and pending are frozen; all inputs are ignored until reset. halt has priority in every state.

## Timing
- Reset values:
  - PC = RESET_PC
  - pending = 0, halted = 0
  - ras_empty = 1, ras_full = 0
  - RAS pointers and count = 0; entry contents are don't-care
- All state updates on posedge CLK. nRST is asynchronous, so a reset mid-stall or mid-halt discards any pending redirect and all RAS contents immediately.
- Redirect latency: redirect_valid with pc_en=1 in cycle N → PC = target in N+1.
- RAS pop latency: ret in cycle N → PC = top in N+1.
- npc, ras_empty, ras_full, pending and halted are combinational from registered state. They have no input-to-output combinational paths, except npc, which follows PC.

## Structure
- cpu_types_pkg gains:
  - `pc_state_t` enum: RUN, HELD, HALTED
  - `PC_RESET_DEFAULT` constant
- Sub-module `pc_ras`, parameters WIDTH and RAS_DEPTH.
  - Inputs: push, pop, push_data.
  - Outputs: top, empty, full.
  - Circular buffer with top pointer and saturating count; push+pop in one cycle performs a replace.
- pc_seq contains the state machine, the priority next-PC mux, the pending register and the alignment masking.

## Test plan
- Reset with RESET_PC=0x200, pc_en=1 for 3 cycles → PC sequence 0x200, 0x204, 0x208, 0x20C; ras_empty=1.
- pc_en=0, redirect_valid with 0x1000 for one cycle, hold pc_en=0 for 3 cycles, then pc_en=1 → pending=1 while stalled, PC unchanged, then PC=0x1000 one cycle after release, pending=0.
- Stalled redirects 0x1000 then 0x2000 → on release PC=0x2000 (last redirect wins).
- At PC=0x40: call; at 0x80: call; then ret, ret → PCs after the rets are 0x84, then 0x44, and ras_empty=1. A further ret → PC=npc with no underflow.
- RAS_DEPTH=4: five calls at 0x10, 0x20, 0x30, 0x40, 0x50, then five rets → targets 0x54, 0x44, 0x34, 0x24, then sequential; ras_full asserted after the fourth call.
- Coverage scenarios:
  - halt with redirect_valid in the same cycle → halted=1, PC frozen for 10 cycles
  - assert nRST mid-halt → PC=RESET_PC, halted=0
  - PC=0xFFFFFFFC with pc_en=1 → PC=0x0
  - redirect_pc=0x103 → PC=0x100
